// File: rtl/mcmem_arbiter.sv
// mcmem_arbiter: two-requester arbiter/sequencer for the multicycle CPU's single-port
// synchronous data memory (fetch = requester 0, load/store = requester 1).
`default_nettype none

module mcmem_arbiter #(
   parameter int RD_LAT    = 2,
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic        mem_we,
   input  logic [31:0] mem_dataout
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;
   logic               ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_datain_q, mem_datain_d;
   logic               mem_we_q, mem_we_d;
   logic               win;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_datain_d = mem_datain_q;
      mem_we_d     = mem_we_q;
      win          = 1'b0;

      case (state_q)
         IDLE: begin
            mem_we_d = 1'b0;
            if (req0 || req1) begin
               if (req0 && !req1)      win = 1'b0;
               else if (!req0 && req1) win = 1'b1;
               else if (FIXED_PRI)     win = 1'b0;
               else                    win = ptr_q;
               // pointer always ends up favouring whoever did not get this grant
               ptr_d        = ~win;
               owner_d      = win;
               mem_addr_d   = win ? addr1  : addr0;
               mem_datain_d = win ? wdata1 : wdata0;
               mem_we_d     = win ? we1    : we0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            mem_we_d = 1'b0;
            if (mem_we_q) begin
               state_d = IDLE;
            end else if (RD_LAT == 1) begin
               state_d = RESP;
            end else begin
               cnt_d   = CNT_W'(RD_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         ptr_q        <= 1'b0;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
         mem_datain_q <= '0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_datain_q <= mem_datain_d;
         mem_we_q     <= mem_we_d;
      end
   end

   assign gnt0       = (state_q == ISSUE) && !owner_q;
   assign gnt1       = (state_q == ISSUE) &&  owner_q;
   assign rvalid0    = (state_q == RESP)  && !owner_q;
   assign rvalid1    = (state_q == RESP)  &&  owner_q;
   assign rdata      = (state_q == RESP) ? mem_dataout : 32'd0;
   assign busy       = (state_q != IDLE);
   assign mem_addr   = mem_addr_q;
   assign mem_datain = mem_datain_q;
   assign mem_we     = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_mcmem_arbiter.sv
// Directed bench for mcmem_arbiter: three builds (round-robin/RD_LAT=2, fixed
// priority/RD_LAT=2, round-robin/RD_LAT=1), each with its own memory model.
`default_nettype none

module tb_mcmem_arbiter;

   logic        clk = 1'b0;
   logic        clrn;
   logic        req0[3], we0[3], req1[3], we1[3];
   logic [31:0] addr0[3], wdata0[3], addr1[3], wdata1[3];
   logic        gnt0[3], gnt1[3], rvalid0[3], rvalid1[3], busy[3], mem_we[3];
   logic [31:0] rdata[3], mem_addr[3], mem_datain[3], mem_dataout[3];

   logic [31:0] mdl[3][64];
   logic [5:0]  ma_q[3];
   logic [31:0] mo_q[3];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mcmem_arbiter #(.RD_LAT(2), .FIXED_PRI(1'b0)) u_rr (
      .clk(clk), .clrn(clrn),
      .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
      .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
      .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
      .rdata(rdata[0]), .busy(busy[0]), .mem_addr(mem_addr[0]),
      .mem_datain(mem_datain[0]), .mem_we(mem_we[0]), .mem_dataout(mem_dataout[0]));

   mcmem_arbiter #(.RD_LAT(2), .FIXED_PRI(1'b1)) u_fp (
      .clk(clk), .clrn(clrn),
      .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
      .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
      .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
      .rdata(rdata[1]), .busy(busy[1]), .mem_addr(mem_addr[1]),
      .mem_datain(mem_datain[1]), .mem_we(mem_we[1]), .mem_dataout(mem_dataout[1]));

   mcmem_arbiter #(.RD_LAT(1), .FIXED_PRI(1'b0)) u_l1 (
      .clk(clk), .clrn(clrn),
      .req0(req0[2]), .we0(we0[2]), .addr0(addr0[2]), .wdata0(wdata0[2]),
      .req1(req1[2]), .we1(we1[2]), .addr1(addr1[2]), .wdata1(wdata1[2]),
      .gnt0(gnt0[2]), .gnt1(gnt1[2]), .rvalid0(rvalid0[2]), .rvalid1(rvalid1[2]),
      .rdata(rdata[2]), .busy(busy[2]), .mem_addr(mem_addr[2]),
      .mem_datain(mem_datain[2]), .mem_we(mem_we[2]), .mem_dataout(mem_dataout[2]));

   // memory: registered inputs on every build, extra output register on the RD_LAT=2 builds
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (mem_we[k]) mdl[k][mem_addr[k][7:2]] <= mem_datain[k];
         ma_q[k] <= mem_addr[k][7:2];
         mo_q[k] <= mdl[k][ma_q[k]];
      end
   end

   assign mem_dataout[0] = mo_q[0];
   assign mem_dataout[1] = mo_q[1];
   assign mem_dataout[2] = mdl[2][ma_q[2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input bit who, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
      if (!who) begin
         req0[k] = r; we0[k] = w; addr0[k] = a; wdata0[k] = d;
      end else begin
         req1[k] = r; we1[k] = w; addr1[k] = a; wdata1[k] = d;
      end
   endtask

   task automatic wr(input int k, input bit who, input logic [31:0] a, input logic [31:0] d);
      drive(k, who, 1'b1, 1'b1, a, d);
      step();
      drive(k, who, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
   endtask

   initial begin
      int cnt;
      for (int k = 0; k < 3; k++) begin
         drive(k, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
         drive(k, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      clrn = 1'b0;
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         check("rst_gnt",   32'({gnt0[k], gnt1[k]}), 32'd0);
         check("rst_rv",    32'({rvalid0[k], rvalid1[k]}), 32'd0);
         check("rst_busy",  32'(busy[k]), 32'd0);
         check("rst_we",    32'(mem_we[k]), 32'd0);
         check("rst_addr",  mem_addr[k], 32'd0);
         check("rst_wdata", mem_datain[k], 32'd0);
      end
      clrn = 1'b1;

      // write from requester 0
      drive(0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      check("wr_t0_busy", 32'(busy[0]), 32'd0);
      step();
      check("wr_gnt0", 32'(gnt0[0]), 32'd1);
      check("wr_gnt1", 32'(gnt1[0]), 32'd0);
      check("wr_we",   32'(mem_we[0]), 32'd1);
      check("wr_addr", mem_addr[0], 32'h10);
      check("wr_data", mem_datain[0], 32'hDEAD_BEEF);
      drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      check("wr_t2_busy", 32'(busy[0]), 32'd0);
      check("wr_t2_we",   32'(mem_we[0]), 32'd0);
      check("wr_word4",   mdl[0][4], 32'hDEAD_BEEF);

      // read back by requester 1
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
      step();
      check("rd_gnt1", 32'(gnt1[0]), 32'd1);
      check("rd_gnt0", 32'(gnt0[0]), 32'd0);
      drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      check("rd_t2_rv",   32'(rvalid1[0]), 32'd0);
      check("rd_t2_busy", 32'(busy[0]), 32'd1);
      step();
      check("rd_rv1",   32'(rvalid1[0]), 32'd1);
      check("rd_rv0",   32'(rvalid0[0]), 32'd0);
      check("rd_rdata", rdata[0], 32'hDEAD_BEEF);
      step();
      check("rd_t4_busy", 32'(busy[0]), 32'd0);
      check("rd_t4_rv",   32'(rvalid1[0]), 32'd0);

      // simultaneous reads from a fresh reset
      wr(0, 1'b0, 32'h20, 32'hA5A5_0001);
      wr(0, 1'b1, 32'h24, 32'h5A5A_0002);
      clrn = 1'b0;
      step();
      clrn = 1'b1;
      drive(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
      drive(0, 1'b1, 1'b1, 1'b0, 32'h24, 32'd0);
      step();
      check("sim_gnt0", 32'(gnt0[0]), 32'd1);
      check("sim_gnt1", 32'(gnt1[0]), 32'd0);
      drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      check("sim_rv0",    32'({rvalid0[0], rvalid1[0]}), 32'b10);
      check("sim_rdata0", rdata[0], 32'hA5A5_0001);
      step();
      check("sim_t4_gnt1", 32'(gnt1[0]), 32'd0);
      step();
      check("sim_t5_gnt1", 32'({gnt0[0], gnt1[0]}), 32'b01);
      drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      check("sim_rv1",    32'({rvalid0[0], rvalid1[0]}), 32'b01);
      check("sim_rdata1", rdata[0], 32'h5A5A_0002);
      step();

      // continuous write contention, round-robin
      drive(0, 1'b0, 1'b1, 1'b1, 32'h30, 32'h100);
      drive(0, 1'b1, 1'b1, 1'b1, 32'h34, 32'h200);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rr_gnt0", 32'(gnt0[0]), 32'((i % 2) == 0));
         check("rr_gnt1", 32'(gnt1[0]), 32'((i % 2) == 1));
         step();
      end
      drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();

      // continuous write contention, fixed priority
      cnt = 0;
      drive(1, 1'b0, 1'b1, 1'b1, 32'h30, 32'h100);
      drive(1, 1'b1, 1'b1, 1'b1, 32'h34, 32'h200);
      for (int i = 0; i < 4; i++) begin
         step();
         check("fp_gnt0", 32'(gnt0[1]), 32'd1);
         cnt += int'(gnt1[1]);
         step();
         cnt += int'(gnt1[1]);
      end
      drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check("fp_no_gnt1", 32'(cnt), 32'd0);

      // reset in the WAIT cycle abandons the read
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
      step();
      check("rst_rd_gnt1", 32'(gnt1[0]), 32'd1);
      drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      check("rst_rd_wait", 32'(busy[0]), 32'd1);
      clrn = 1'b0;
      step();
      clrn = 1'b1;
      check("rst_rd_busy", 32'(busy[0]), 32'd0);
      check("rst_rd_outs", 32'({gnt0[0], gnt1[0], rvalid0[0], rvalid1[0], mem_we[0]}), 32'd0);
      check("rst_rd_addr", mem_addr[0], 32'd0);
      check("rst_rd_data", mem_datain[0], 32'd0);
      cnt = 0;
      repeat (4) begin
         step();
         cnt += int'(rvalid0[0] | rvalid1[0]);
      end
      check("rst_rd_norv", 32'(cnt), 32'd0);
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
      step();
      check("rst_rd2_gnt1", 32'(gnt1[0]), 32'd1);
      drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      check("rst_rd2_rv1",   32'(rvalid1[0]), 32'd1);
      check("rst_rd2_rdata", rdata[0], 32'hDEAD_BEEF);

      // RD_LAT=1 build
      drive(2, 1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFE_0001);
      step();
      check("l1_wr_gnt0", 32'(gnt0[2]), 32'd1);
      check("l1_wr_we",   32'(mem_we[2]), 32'd1);
      drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      check("l1_wr_busy", 32'(busy[2]), 32'd0);
      drive(2, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
      step();
      check("l1_rd_gnt1", 32'(gnt1[2]), 32'd1);
      check("l1_rd_rv",   32'(rvalid1[2]), 32'd0);
      drive(2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      check("l1_rd_rv1",   32'(rvalid1[2]), 32'd1);
      check("l1_rd_rdata", rdata[2], 32'hCAFE_0001);
      step();
      check("l1_rd_idle", 32'({busy[2], rvalid1[2]}), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mcmem_arbiter.md
Name: mcmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port synchronous data memory of the multicycle CPU.
- The memory has registered address/data/we inputs and a registered data output on one clock.
- Requester 0 is the instruction-fetch path and requester 1 is the load/store path.
- The block grants one requester at a time, drives the memory port from registers, times the read latency, and returns read data with a valid pulse to the owning requester.

Parameters:
- RD_LAT, 2, clock edges from the memory's address capture to valid read data (>=1; memory with in+out registers = 2)
- FIXED_PRI, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

Ports:
- clk  input  1  system clock; memory's memclk is this same clock
- clrn  input  1  synchronous active-low reset
- req0  input  1  requester 0 access request; held until gnt0
- we0  input  1  requester 0 write enable (1 = write)
- addr0  input  32  requester 0 byte address
- wdata0  input  32  requester 0 write data
- req1  input  1  requester 1 access request
- we1  input  1  requester 1 write enable
- addr1  input  32  requester 1 byte address
- wdata1  input  32  requester 1 write data
- gnt0  output  1  one-cycle grant pulse to requester 0
- gnt1  output  1  one-cycle grant pulse to requester 1
- rvalid0  output  1  read data valid for requester 0
- rvalid1  output  1  read data valid for requester 1
- rdata  output  32  read data, shared; meaningful only while rvalid0 or rvalid1 is high
- busy  output  1  high in every state except IDLE
- mem_addr  output  32  memory address (memory decodes bits [7:2])
- mem_datain  output  32  memory write data
- mem_we  output  1  memory write enable
- mem_dataout  input  32  memory read data

Behaviour:
- All sequential logic updates on posedge clk. Reset is synchronous: clrn==0 at an edge forces the reset state.
- Reset state:
  - state=IDLE.
  - gnt0, gnt1, rvalid0, rvalid1, mem_we, busy = 0.
  - mem_addr, mem_datain = 0.
  - Round-robin pointer gives requester 0 priority.
  - Wait counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE (cycle T0): if req0|req1 is high at the edge:
  - Select the winner.
  - Register the winner's addr/wdata/we into mem_addr/mem_datain/mem_we.
  - Register the winner id and go to ISSUE.
  - If neither request is high, remain in IDLE with mem_we=0.
- Winner selection:
  - Only one request high: that requester wins.
  - Both high, FIXED_PRI=1: requester 0 wins.
  - Both high, FIXED_PRI=0: the requester the pointer favours wins. The pointer then moves to favour the loser; it updates on every grant.
- ISSUE (cycle T1):
  - mem_* outputs are stable and gnt of the winner = 1, for exactly this cycle.
  - The memory captures the address, data and we at the end of T1.
  - Write: mem_we is cleared at the end of T1, then go to IDLE. A write occupies 2 cycles.
  - Read: go to WAIT with counter = RD_LAT-1. If RD_LAT==1, go directly to RESP.
- WAIT: decrement the counter each cycle; move to RESP when the counter reaches 1.
- RESP (cycle T1+RD_LAT):
  - rvalid of the winner = 1 and rdata = mem_dataout, combinational pass-through of that cycle.
  - Then go to IDLE. A read occupies RD_LAT+2 cycles; with RD_LAT=2, T1..T3 is 3 cycles after T0.
- No arbitration happens in ISSUE, WAIT or RESP. Requests are sampled only in IDLE.
- Requester protocol:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req, or present a new access, on the cycle after gnt.
  - The block never grants the same request twice, because the cycle after ISSUE is never IDLE-sampling of stale req except for writes. For writes, the requester has already had the gnt edge to drop req.
- Request dropped after IDLE captured it: the transaction still completes. The captured values are authoritative.
- Only one transaction is outstanding at a time. rvalid0 and rvalid1 are never high together. gnt and rvalid never occur for the non-owner.
- Reset mid-operation:
  - All state is cleared at the reset edge and any pending read is abandoned; no rvalid is issued.
  - A write that was in ISSUE during the reset edge is still captured by the memory; that is acceptable.
  - After reset deasserts, the first arbitration favours requester 0.
- Addresses pass through unmodified. Misaligned or out-of-range bits are the requester's responsibility.

Test Plan:
- Write: req0=1, we0=1, addr0=0x0000_0010, wdata0=0xDEAD_BEEF at T0 -> gnt0=1 and mem_we=1, mem_addr=0x10, mem_datain=0xDEADBEEF at T1; busy=0 at T2; memory word 4 = 0xDEADBEEF.
- Read-back: req1=1, we1=0, addr1=0x10 -> gnt1 at T1; rvalid1=1 with rdata=0xDEADBEEF at T3; rvalid0 stays 0; IDLE at T4.
- Simultaneous: req0 and req1 both read from reset, FIXED_PRI=0 -> gnt0 first; gnt1 on requester 1's ISSUE cycle, 5 cycles later (T0+5 with RD_LAT=2); each rvalid carries its own word.
- Continuous contention: req0 and req1 both held, with immediate re-request after each gnt, writes only -> grants alternate 0,1,0,1. With FIXED_PRI=1 -> requester 0 is granted on every arbitration and gnt1 never occurs.
- Reset mid-read: clrn=0 on the WAIT cycle -> next cycle all outputs 0, state IDLE, no rvalid ever issued for that read; a following req1 read is served normally.
- RD_LAT=1 build: read -> rvalid two cycles after T0 (ISSUE then RESP); write timing unchanged.
